// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types for the 4-lane round-robin mux arbiter
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] src_t;

    typedef enum logic {
        IDLE,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - picks the first set mask bit after ptr (MUX_ARB_FIXED_PRIO_EN forces ptr to 3)
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  src_t             ptr,
    output logic             any,
    output src_t             win
);

    src_t eff_ptr;

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign eff_ptr    = 2'd3;
`else
    assign eff_ptr = ptr;
`endif

    // Walk ptr+1 .. ptr+4 (mod 4); the first hit wins, ptr itself is checked last.
    always_comb begin
        src_t idx;
        any = 1'b0;
        win = '0;
        idx = eff_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = idx + 2'd1;
            if (!any && mask[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_4_rr_arbiter.sv
// rtl/mux_4_rr_arbiter.sv - round-robin 4:1 mux with registered valid/ready output
// Optional MUX_ARB_FIXED_PRIO_EN selects fixed priority (lane 0 highest) and drops the pointer.
module mux_4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output src_t             out_src,
    output logic [N_REQ-1:0] ack
);

    arb_state_t       state;
    logic             handshake;
    logic [N_REQ-1:0] mask;
    logic [W-1:0]     lanes [0:N_REQ-1];
    src_t             ptr;
    logic             any;
    src_t             win;

    assign lanes     = '{d0, d1, d2, d3};
    assign handshake = out_valid & out_ready;

    always_comb begin
        ack = '0;
        ack[out_src] = handshake;
    end

    // The lane being acknowledged cannot be re-granted in the same cycle.
    assign mask = req & ~ack;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign ptr = 2'd3;
`else
    src_t last;

    // On a handshake the search must start after the lane just accepted.
    assign ptr = handshake ? out_src : last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 2'd3;
        end else if (handshake) begin
            last <= out_src;
        end
    end
`endif

    rr_pick_4 u_pick (
        .mask (mask),
        .ptr  (ptr),
        .any  (any),
        .win  (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        out_data  <= lanes[win];
                        out_src   <= win;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        if (any) begin
                            out_data <= lanes[win];
                            out_src  <= win;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// tb/tb_mux_4_rr_arbiter.sv - directed self-checking bench for mux_4_rr_arbiter
module tb_mux_4_rr_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic [3:0]   ack;

    int n_checks;
    int n_fail;

    mux_4_rr_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_checks++;
        if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d want 0", out_src); end
        n_checks++;
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    endtask

    task automatic test_single();
        do_reset();
        d2  = 4'hc;
        req = 4'b0100;
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_src !== 2'd2) begin n_fail++; $display("FAIL single_src got %0d want 2", out_src); end
        n_checks++;
        if (out_data !== 4'hc) begin n_fail++; $display("FAIL single_data got %h want c", out_data); end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got %b want 0100", ack); end
        step();
        req = 4'b0000;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", out_valid); end
        n_checks++;
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_after got %b want 0000", ack); end
    endtask

    task automatic test_rotation();
        logic [1:0]   exp_src [5];
        logic [W-1:0] exp_dat [5];
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
        do_reset();
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out_src !== exp_src[i]) begin
                n_fail++; $display("FAIL rot_src[%0d] got %0d want %0d", i, out_src, exp_src[i]);
            end
            n_checks++;
            if (out_data !== exp_dat[i]) begin
                n_fail++; $display("FAIL rot_data[%0d] got %h want %h", i, out_data, exp_dat[i]);
            end
            n_checks++;
            if (ack !== (4'b0001 << exp_src[i])) begin
                n_fail++; $display("FAIL rot_ack[%0d] got %b want %b", i, ack, 4'b0001 << exp_src[i]);
            end
        end
        req       = 4'b0000;
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        d1  = 4'h5;
        req = 4'b0010;
        step();
        req = 4'b0000;
        d1  = 4'h7;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h5 || ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall[%0d] got v=%b src=%0d data=%h ack=%b want v=1 src=1 data=5 ack=0000",
                         i, out_valid, out_src, out_data, ack);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL stall_ack got %b want 0010", ack); end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            n_fail++; $display("FAIL stall_single_ack got v=%b ack=%b want v=0 ack=0000", out_valid, ack);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_lane3_repeat();
        do_reset();
        d3        = 4'h9;
        req       = 4'b1000;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_src !== 2'd3 || out_data !== 4'h9 || ack !== 4'b1000) begin
            n_fail++; $display("FAIL l3_first got src=%0d data=%h ack=%b want src=3 data=9 ack=1000", out_src, out_data, ack);
        end
        step();
        d3 = 4'h6;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            n_fail++; $display("FAIL l3_no_double got v=%b ack=%b want v=0 ack=0000", out_valid, ack);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 4'h6) begin
            n_fail++; $display("FAIL l3_regrant got v=%b src=%0d data=%h want v=1 src=3 data=6", out_valid, out_src, out_data);
        end
        req       = 4'b0000;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d2  = 4'h3;
        req = 4'b0100;
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_hold got %b want 1", out_valid); end
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_discard got v=%b ack=%b want v=0 ack=0000", out_valid, ack);
        end
        rst_n = 1'b1;
        d0  = 4'he;
        d3  = 4'hf;
        req = 4'b1001;
        step();
        n_checks++;
        if (out_src !== 2'd0 || out_data !== 4'he) begin
            n_fail++; $display("FAIL rmid_first got src=%0d data=%h want src=0 data=e", out_src, out_data);
        end
        req = 4'b0000;
    endtask

    task automatic test_pointer_mode();
        logic [1:0] exp;
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp = 2'd0;
`else
        exp = 2'd1;
`endif
        do_reset();
        d0 = 4'h8; d1 = 4'h4;
        req       = 4'b0001;
        out_ready = 1'b1;
        step();
        step();
        req = 4'b0011;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ptr_idle got %b want 0", out_valid); end
        step();
        n_checks++;
        if (out_src !== exp) begin n_fail++; $display("FAIL ptr_pick got %0d want %0d", out_src, exp); end
        req       = 4'b0000;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_single();
        test_rotation();
        test_stall();
        test_lane3_repeat();
        test_reset_mid();
        test_pointer_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
